// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator core: opcodes, FSM states, ALU selects, skip conditions.
package acc_cpu_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0100;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_HALT  = 4'h7,
        OP_SKIP  = 4'h8,
        OP_JUMP  = 4'h9,
        OP_CLEAR = 4'hA
    } opcode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DECODE,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_EXEC,
        ST_STORE,
        ST_HALT
    } state_t;

    localparam logic [1:0] ALU_OR  = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    typedef enum logic [1:0] {
        SKC_NEG   = 2'b00,
        SKC_ZERO  = 2'b01,
        SKC_POS   = 2'b10,
        SKC_NEVER = 2'b11
    } skip_cond_t;

    function automatic logic [1:0] alu_sel_of(opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_OR;
        endcase
    endfunction

    function automatic logic is_mem_op(opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) ||
               (op == OP_SUB)  || (op == OP_AND)   || (op == OP_OR);
    endfunction

    function automatic logic is_defined_op(opcode_t op);
        return (op >= OP_LOAD) && (op <= OP_CLEAR);
    endfunction

endpackage

// File: rtl/acc_cpu_core_if.sv
// Single-port synchronous RAM bus between the core (master) and the RAM (slave).
// Read data is valid the cycle after a cs&oe request; a write commits on the edge with cs&we.
interface acc_cpu_core_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport master (
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe,
        output mem_rdata
    );
endinterface

// File: rtl/acc_cpu_core_alu.sv
// Purpose: two-operand ALU (OR/ADD/SUB/AND), result wraps at WIDTH bits.
// Latency: combinational.
// Backpressure: none.
module alu
    import acc_cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out
);
    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            ALU_OR:  ALU_Out = A | B;
            ALU_ADD: ALU_Out = A + B;
            ALU_SUB: ALU_Out = A - B;
            ALU_AND: ALU_Out = A & B;
            default: ALU_Out = '0;
        endcase
    end
endmodule

// File: rtl/acc_cpu_core.sv
// Purpose: accumulator CPU, fetch/decode/execute over a sync RAM; ACC_CPU_ILLEGAL_TRAP_EN traps undefined opcodes.
// Latency: 3 cycles SKIP/JUMP/CLEAR/NOP, 5 STORE, 6 LOAD/ALU, HALT reached 3 cycles after fetch.
// Backpressure: none; RAM is assumed to answer every request the next cycle, start only honoured in IDLE/HALT.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    acc_cpu_core_if.master        mem,
    output logic                  halted,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ac_o
);

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t                state;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] mbr;
    logic [DATA_WIDTH-1:0] ac;
    logic [DATA_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [1:0]            alu_sel;
    opcode_t               opcode;
    logic                  skip_taken;
    logic                  cs;
    logic                  we;
    logic                  oe;

    assign opcode  = opcode_t'(ir[DATA_WIDTH-1 -: 4]);
    assign operand = DATA_WIDTH'(ir[11:0]);
    assign alu_sel = alu_sel_of(opcode);

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .A       (ac),
        .B       (mbr),
        .ALU_Sel (alu_sel),
        .ALU_Out (alu_out)
    );

    always_comb begin
        skip_taken = 1'b0;
        case (skip_cond_t'(ir[11:10]))
            SKC_NEG:   skip_taken = ac[DATA_WIDTH-1];
            SKC_ZERO:  skip_taken = (ac == '0);
            SKC_POS:   skip_taken = !ac[DATA_WIDTH-1] && (ac != '0);
            SKC_NEVER: skip_taken = 1'b0;
            default:   skip_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // MAR holds the address through the wait/store cycles; only request cycles bypass it.
    always_comb begin
        state_d = state;
        cs      = 1'b0;
        we      = 1'b0;
        oe      = 1'b0;
        addr_d  = mar;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                cs      = 1'b1;
                oe      = 1'b1;
                addr_d  = pc;
                state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                cs      = 1'b1;
                oe      = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_mem_op(opcode))                  state_d = ST_MEM_REQ;
                else if (opcode == OP_HALT)             state_d = ST_HALT;
                else if (TRAP_EN && !is_defined_op(opcode)) state_d = ST_HALT;
                else                                    state_d = ST_FETCH;
            end
            ST_MEM_REQ: begin
                cs     = 1'b1;
                addr_d = operand;
                if (opcode == OP_STORE) begin
                    state_d = ST_STORE;
                end else begin
                    oe      = 1'b1;
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                cs      = 1'b1;
                oe      = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
            end
            ST_STORE: begin
                cs      = 1'b1;
                we      = 1'b1;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RESET_PC;
            ir  <= '0;
            mbr <= '0;
            ac  <= '0;
            mar <= '0;
        end else begin
            case (state)
                ST_FETCH:      mar <= pc;
                ST_FETCH_WAIT: ir  <= mem.mem_rdata;
                ST_DECODE: begin
                    case (opcode)
                        OP_JUMP: pc <= operand;
                        OP_SKIP: pc <= pc + (skip_taken ? DATA_WIDTH'(2) : DATA_WIDTH'(1));
                        default: pc <= pc + DATA_WIDTH'(1);
                    endcase
                    if (opcode == OP_CLEAR) ac <= '0;
                end
                ST_MEM_REQ: begin
                    mar <= operand;
                    if (opcode == OP_STORE) mbr <= ac;
                end
                ST_MEM_WAIT:   mbr <= mem.mem_rdata;
                ST_EXEC:       ac  <= (opcode == OP_LOAD) ? mbr : alu_out;
                default: ;
            endcase
        end
    end

`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky until reset so software can inspect it after the trap halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state == ST_DECODE && !is_defined_op(opcode)) begin
            illegal_q <= 1'b1;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign mem.mem_addr  = ADDR_WIDTH'(addr_d);
    assign mem.mem_wdata = mbr;
    assign mem.mem_cs    = cs;
    assign mem.mem_we    = we;
    assign mem.mem_oe    = oe;

    assign halted = (state == ST_HALT);
    assign pc_o   = pc;
    assign ac_o   = ac;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: RAM model, ISA-level reference model, per-feature test tasks.
module tb_acc_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_w;
    logic        halted, illegal, halted_w, illegal_w;
    logic [15:0] pc_o, ac_o, pc_w, ac_w;

    logic        ld_en;
    logic [15:0] ld_addr, ld_data;
    logic [15:0] ram  [0:65535];
    logic [15:0] mmem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    int          we_cycles = 0;
    int          rw_conflicts = 0;
    int          cs_while_halted = 0;
    logic [17:0] last_we_addr;
    logic [15:0] last_we_data;

    always #5 clk = ~clk;

    acc_cpu_core_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) bus ();
    acc_cpu_core_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) bus_w ();

    acc_cpu_core dut (
        .clk(clk), .rst(rst), .start(start), .mem(bus.master),
        .halted(halted), .illegal(illegal), .pc_o(pc_o), .ac_o(ac_o)
    );

    acc_cpu_core #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .mem(bus_w.master),
        .halted(halted_w), .illegal(illegal_w), .pc_o(pc_w), .ac_o(ac_w)
    );

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr[15:0]] <= bus.mem_wdata;
        if (bus.mem_cs && bus.mem_oe && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr[15:0]];
        if (bus_w.mem_cs && bus_w.mem_oe) bus_w.mem_rdata <= ram[bus_w.mem_addr[15:0]];
    end

    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_cycles++;
            last_we_addr = bus.mem_addr;
            last_we_data = bus.mem_wdata;
        end
        if (bus.mem_we && bus.mem_oe) rw_conflicts++;
        if (halted && bus.mem_cs) cs_while_halted++;
    end

    // ISA-level reference: executes instructions on mmem, summing cycles per instruction class.
    task automatic model_run(input logic [15:0] pc0, ac0, output logic [15:0] pc, ac,
                             output int cyc, output bit ill, output int st);
        logic [15:0] ir, ea;
        bit done, take;
        pc = pc0; ac = ac0; cyc = 0; ill = 0; st = 0; done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            ir = mmem[pc];
            pc = pc + 16'd1;
            ea = {4'h0, ir[11:0]};
            case (ir[15:12])
                4'h1: begin ac = mmem[ea];      cyc += 6; end
                4'h2: begin mmem[ea] = ac; st++; cyc += 5; end
                4'h3: begin ac = ac + mmem[ea]; cyc += 6; end
                4'h4: begin ac = ac - mmem[ea]; cyc += 6; end
                4'h5: begin ac = ac & mmem[ea]; cyc += 6; end
                4'h6: begin ac = ac | mmem[ea]; cyc += 6; end
                4'h7: begin cyc += 3; done = 1; end
                4'h8: begin
                    case (ir[11:10])
                        2'b00:   take = ($signed(ac) < 0);
                        2'b01:   take = (ac == 16'h0);
                        2'b10:   take = ($signed(ac) > 0);
                        default: take = 0;
                    endcase
                    if (take) pc = pc + 16'd1;
                    cyc += 3;
                end
                4'h9: begin pc = ea;   cyc += 3; end
                4'hA: begin ac = 16'h0; cyc += 3; end
                default: begin
                    cyc += 3;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
                    ill = 1; done = 1;
`endif
                end
            endcase
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; start_w = 1'b0; ld_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
        mmem[a] = d;
    endtask

    task automatic run_dut(input int budget, input bit noisy, output int cycles, output bit tmo);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (!halted && cycles < budget) begin
            if (noisy) start = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1 cycles++;
        end
        start = 1'b0;
        tmo = !halted;
    endtask

    task automatic exec_prog(input logic [15:0] pc0, ac0, input bit noisy,
                             output logic [15:0] epc, eac, output int ecyc, dcyc,
                             output bit eill, output int est, dst, output bit tmo);
        int st0;
        model_run(pc0, ac0, epc, eac, ecyc, eill, est);
        st0 = we_cycles;
        run_dut(300, noisy, dcyc, tmo);
        dst = we_cycles - st0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start_w = 1'b0; ld_en = 1'b0;
        #1;
        vectors++;
        if ({pc_o, ac_o} !== {16'h0100, 16'h0000}) begin
            miscompares++; $display("FAIL reset_pc_ac: got %h/%h want 0100/0000", pc_o, ac_o);
        end
        vectors++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_cs, bus.mem_we, bus.mem_oe} !== 37'h0) begin
            miscompares++; $display("FAIL reset_bus: addr %h wdata %h cs/we/oe %b%b%b want all 0",
                                    bus.mem_addr, bus.mem_wdata, bus.mem_cs, bus.mem_we, bus.mem_oe);
        end
        vectors++;
        if ({halted, illegal} !== 2'b00) begin
            miscompares++; $display("FAIL reset_flags: halted/illegal %b%b want 00", halted, illegal);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({bus.mem_cs, pc_o} !== {1'b0, 16'h0100}) begin
            miscompares++; $display("FAIL idle_no_start: cs %b pc %h want 0/0100", bus.mem_cs, pc_o);
        end
    endtask

    task automatic test_load_halt();
        logic [15:0] epc, eac; int ecyc, dcyc, est, dst; bit eill, tmo;
        do_reset();
        put(16'h0100, 16'h1124); put(16'h0124, 16'h0005); put(16'h0101, 16'h7000);
        exec_prog(16'h0100, 16'h0000, 1'b0, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
        vectors++;
        if (tmo || halted !== 1'b1) begin
            miscompares++; $display("FAIL load_halt_halted: halted %b want 1", halted);
        end
        vectors++;
        if ({pc_o, ac_o} !== {epc, eac}) begin
            miscompares++; $display("FAIL load_halt_state: pc/ac %h/%h want %h/%h", pc_o, ac_o, epc, eac);
        end
        vectors++;
        if (dcyc !== ecyc) begin
            miscompares++; $display("FAIL load_halt_cycles: got %0d want %0d", dcyc, ecyc);
        end
    endtask

    task automatic test_alu();
        logic [15:0] epc, eac, a, b; int ecyc, dcyc, est, dst; bit eill, tmo;
        logic [3:0] ops [0:4];
        ops[0] = 4'h3; ops[1] = 4'h4; ops[2] = 4'h5; ops[3] = 4'h6; ops[4] = 4'h1;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            if (i < 4) begin
                op = ops[i]; a = 16'h00F0; b = 16'h0F0F;
            end else begin
                op = ops[$urandom_range(0, 4)]; a = 16'($urandom); b = 16'($urandom);
            end
            do_reset();
            put(16'h0200, a); put(16'h0201, b);
            put(16'h0100, 16'h1200); put(16'h0101, {op, 12'h201}); put(16'h0102, 16'h7000);
            exec_prog(16'h0100, 16'h0000, i[0], epc, eac, ecyc, dcyc, eill, est, dst, tmo);
            vectors++;
            if (tmo || ac_o !== eac) begin
                miscompares++; $display("FAIL alu_op%h: %h,%h ac %h want %h", op, a, b, ac_o, eac);
            end
            vectors++;
            if (dcyc !== ecyc) begin
                miscompares++; $display("FAIL alu_cycles_op%h: got %0d want %0d", op, dcyc, ecyc);
            end
        end
    endtask

    task automatic test_store_load();
        logic [15:0] epc, eac; int ecyc, dcyc, est, dst; bit eill, tmo;
        do_reset();
        put(16'h0200, 16'h1234); put(16'h0130, 16'h0000);
        put(16'h0100, 16'h1200); put(16'h0101, 16'h2130); put(16'h0102, 16'hA000);
        put(16'h0103, 16'h1130); put(16'h0104, 16'h7000);
        exec_prog(16'h0100, 16'h0000, 1'b0, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
        vectors++;
        if (tmo || ac_o !== eac || ram[16'h0130] !== mmem[16'h0130]) begin
            miscompares++; $display("FAIL store_load: ac %h mem %h want %h/%h", ac_o, ram[16'h0130], eac, mmem[16'h0130]);
        end
        vectors++;
        if (dst !== est || last_we_addr !== 18'h00130 || last_we_data !== 16'h1234) begin
            miscompares++; $display("FAIL store_pulse: we cycles %0d addr %h data %h want %0d/00130/1234",
                                    dst, last_we_addr, last_we_data, est);
        end
        vectors++;
        if (dcyc !== ecyc) begin
            miscompares++; $display("FAIL store_cycles: got %0d want %0d", dcyc, ecyc);
        end
    endtask

    task automatic test_skip();
        logic [15:0] epc, eac; int ecyc, dcyc, est, dst; bit eill, tmo;
        logic [31:0] cases [0:8];
        cases[0] = {16'h0000, 16'h8400}; cases[1] = {16'h8000, 16'h8000};
        cases[2] = {16'h0001, 16'h8400}; cases[3] = {16'h0001, 16'h8800};
        cases[4] = {16'h8000, 16'h8800}; cases[5] = {16'h0000, 16'h8800};
        cases[6] = {16'h0000, 16'h8C00}; cases[7] = {16'h0000, 16'h8000};
        cases[8] = {16'h7FFF, 16'h8BFF};
        for (int i = 0; i < 9; i++) begin
            do_reset();
            put(16'h0250, cases[i][31:16]);
            put(16'h0100, 16'h1250); put(16'h0101, 16'h9200);
            put(16'h0200, cases[i][15:0]); put(16'h0201, 16'h7000); put(16'h0202, 16'h7000);
            exec_prog(16'h0100, 16'h0000, 1'b1, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
            vectors++;
            if (tmo || pc_o !== epc || dcyc !== ecyc) begin
                miscompares++; $display("FAIL skip_%0d: ac %h ir %h pc %h cyc %0d want %h/%0d",
                                        i, cases[i][31:16], cases[i][15:0], pc_o, dcyc, epc, ecyc);
            end
        end
    endtask

    task automatic test_jump_restart();
        logic [15:0] epc, eac, epc2, eac2; int ecyc, dcyc, est, dst; bit eill, tmo;
        do_reset();
        put(16'h0100, 16'h9150); put(16'h0150, 16'h7000);
        put(16'h0151, 16'h1260); put(16'h0152, 16'h7000); put(16'h0260, 16'($urandom));
        exec_prog(16'h0100, 16'h0000, 1'b0, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
        vectors++;
        if (tmo || pc_o !== epc || halted !== 1'b1 || dcyc !== ecyc) begin
            miscompares++; $display("FAIL jump_halt: pc %h halted %b cyc %0d want %h/1/%0d", pc_o, halted, dcyc, epc, ecyc);
        end
        exec_prog(epc, eac, 1'b0, epc2, eac2, ecyc, dcyc, eill, est, dst, tmo);
        vectors++;
        if (tmo || {pc_o, ac_o} !== {epc2, eac2} || dcyc !== ecyc) begin
            miscompares++; $display("FAIL restart: pc/ac %h/%h cyc %0d want %h/%h/%0d", pc_o, ac_o, dcyc, epc2, eac2, ecyc);
        end
    endtask

    task automatic test_random();
        logic [15:0] epc, eac; int ecyc, dcyc, est, dst; bit eill, tmo;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int d = 0; d < 16; d++) put(16'h0300 + 16'(d), 16'($urandom));
            for (int k = 0; k < 10; k++) begin
                logic [3:0] op;
                logic [11:0] opd;
                case ($urandom_range(0, 7))
                    0: op = 4'h1; 1: op = 4'h2; 2: op = 4'h3; 3: op = 4'h4;
                    4: op = 4'h5; 5: op = 4'h6; 6: op = 4'h8; default: op = 4'hA;
                endcase
                opd = (op == 4'h8) ? 12'($urandom) : 12'h300 + 12'($urandom_range(0, 15));
                put(16'h0100 + 16'(k), {op, opd});
            end
            put(16'h010A, 16'h7000); put(16'h010B, 16'h7000);
            exec_prog(16'h0100, 16'h0000, 1'b1, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
            vectors++;
            if (tmo || {pc_o, ac_o} !== {epc, eac} || dcyc !== ecyc || dst !== est) begin
                miscompares++; $display("FAIL random_%0d: pc/ac %h/%h cyc %0d st %0d want %h/%h/%0d/%0d",
                                        it, pc_o, ac_o, dcyc, dst, epc, eac, ecyc, est);
            end
            for (int d = 0; d < 16; d++) begin
                vectors++;
                if (ram[16'h0300 + 16'(d)] !== mmem[16'h0300 + 16'(d)]) begin
                    miscompares++; $display("FAIL random_mem_%0d_%0d: got %h want %h",
                                            it, d, ram[16'h0300 + 16'(d)], mmem[16'h0300 + 16'(d)]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] epc, eac; int ecyc, est, cyc; bit eill;
        do_reset();
        put(16'hFFFE, 16'h8400); put(16'hFFFF, 16'h7000); put(16'h0000, 16'h7000);
        model_run(16'hFFFE, 16'h0000, epc, eac, ecyc, eill, est);
        @(negedge clk); start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        cyc = 0;
        while (!halted_w && cyc < 50) begin
            @(posedge clk); #1 cyc++;
        end
        vectors++;
        if (!halted_w || {pc_w, ac_w} !== {epc, eac} || cyc !== ecyc || illegal_w !== 1'b0) begin
            miscompares++; $display("FAIL pc_wrap: pc %h ac %h cyc %0d want %h/%h/%0d", pc_w, ac_w, cyc, epc, eac, ecyc);
        end
    endtask

    task automatic test_rst_store();
        int n;
        do_reset();
        put(16'h0200, 16'hAAAA); put(16'h0140, 16'h5555);
        put(16'h0100, 16'h1200); put(16'h0101, 16'h2140); put(16'h0102, 16'h7000);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (bus.mem_we !== 1'b1 && n < 40) begin
            @(posedge clk); #1 n++;
        end
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++; $display("FAIL rst_store_reach: mem_we %b want 1 within 40 cycles", bus.mem_we);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.mem_we, bus.mem_cs, pc_o, ac_o} !== {2'b00, 16'h0100, 16'h0000}) begin
            miscompares++; $display("FAIL rst_store_async: we/cs %b%b pc %h ac %h want 00/0100/0000",
                                    bus.mem_we, bus.mem_cs, pc_o, ac_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        vectors++;
        if (ram[16'h0140] !== 16'h5555) begin
            miscompares++; $display("FAIL rst_store_mem: got %h want 5555", ram[16'h0140]);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] epc, eac, epc2, eac2; int ecyc, dcyc, est, dst; bit eill, eill2, tmo;
        do_reset();
        put(16'h0100, 16'hF000); put(16'h0101, 16'h7000); put(16'h0102, 16'h7000);
        exec_prog(16'h0100, 16'h0000, 1'b0, epc, eac, ecyc, dcyc, eill, est, dst, tmo);
        vectors++;
        if (tmo || illegal !== eill || pc_o !== epc || dcyc !== ecyc) begin
            miscompares++; $display("FAIL illegal_op: illegal %b pc %h cyc %0d want %b/%h/%0d", illegal, pc_o, dcyc, eill, epc, ecyc);
        end
        exec_prog(epc, eac, 1'b0, epc2, eac2, ecyc, dcyc, eill2, est, dst, tmo);
        vectors++;
        if (tmo || illegal !== (eill | eill2) || pc_o !== epc2) begin
            miscompares++; $display("FAIL illegal_sticky: illegal %b pc %h want %b/%h", illegal, pc_o, eill | eill2, epc2);
        end
        do_reset();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++; $display("FAIL illegal_clear: got %b want 0", illegal);
        end
    endtask

    task automatic test_bus_rules();
        vectors++;
        if (rw_conflicts !== 0 || cs_while_halted !== 0) begin
            miscompares++; $display("FAIL bus_rules: we&oe cycles %0d, cs in halt %0d want 0/0", rw_conflicts, cs_while_halted);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_w = 1'b0; ld_en = 1'b0;
        ld_addr = 16'h0; ld_data = 16'h0;
        test_reset();
        test_load_halt();
        test_alu();
        test_store_load();
        test_skip();
        test_jump_restart();
        test_random();
        test_wrap();
        test_rst_store();
        test_illegal();
        test_bus_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Synthesizable accumulator CPU core: fetches 16-bit instructions from the single-port synchronous RAM (`single_port_sync_ram_large`), decodes them and executes them with the existing `alu`. It replaces the behavioural fetch/decode/execute loop used for bring-up and owns the RAM port after program load. It also provides `start`/`halted` handshaking for the system top.

## Interface
- `ADDR_WIDTH`, 18: RAM address width.
- `DATA_WIDTH`, 16: word width; instruction, AC, MBR and PC are all this width.
- `RESET_PC`, 16'h0100: PC value after reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; leaves IDLE or HALT and begins fetch at current PC.
- `mem_addr` out ADDR_WIDTH: RAM address (MAR), zero-extended from 16 bits.
- `mem_wdata` out DATA_WIDTH: store data (MBR).
- `mem_rdata` in DATA_WIDTH: RAM read data, valid the cycle after a read request.
- `mem_cs`, `mem_we`, `mem_oe` out 1: RAM controls.
- `halted` out 1: core in HALT.
- `illegal` out 1: sticky; set by undefined opcode (trap build only).
- `pc_o`, `ac_o` out DATA_WIDTH: debug views of PC and AC.

## Operation
- ISA: opcode IR[15:12], operand IR[11:0] zero-extended to an address.
  - 1 LOAD: AC←M.
  - 2 STORE: M←AC.
  - 3 ADD: AC←AC+M (ALU_Sel 01).
  - 4 SUB: AC←AC−M (ALU_Sel 10).
  - 5 AND (ALU_Sel 11).
  - 6 OR (ALU_Sel 00).
  - 7 HALT.
  - 8 SKIP: PC+1 extra if the condition holds. Condition by IR[11:10]: 00 AC<0 (signed), 01 AC==0, 10 AC>0 (signed), 11 never.
  - 9 JUMP: PC←IR[11:0].
  - A CLEAR: AC←0.
- States and transitions:
  - IDLE→FETCH on `start`.
  - FETCH: mem_addr=PC, cs=1, oe=1, we=0 → FETCH_WAIT.
  - FETCH_WAIT: IR←mem_rdata → DECODE.
  - DECODE: PC←PC+1.
    - SKIP, JUMP and CLEAR complete here → FETCH.
    - Memory operations → MEM_REQ.
    - HALT → HALT.
  - MEM_REQ: mem_addr=operand.
    - Read ops: oe=1 → MEM_WAIT.
    - STORE: MBR←AC → STORE.
  - MEM_WAIT: MBR←mem_rdata → EXEC.
  - EXEC: AC←MBR (LOAD) or ALU_Out → FETCH.
  - STORE: cs=1, we=1, oe=0, mem_wdata=MBR → FETCH.
  - HALT: PC holds (points past HALT); `start` resumes at that PC.
- PC arithmetic is modulo 2^16: 16'hFFFF+1=0. A skip from FFFE lands on 0000.
- ALU flags are ignored; results wrap at 16 bits.
- `mem_cs` is deasserted in IDLE, DECODE, EXEC and HALT; `we` and `oe` are never both 1.

## Timing
- Reset values: PC=RESET_PC, IR=0, MBR=0, AC=0, state IDLE, mem_addr=0, mem_wdata=0, cs=we=oe=0, halted=0, illegal=0.
- Cycles per instruction, counted from FETCH entry to next FETCH entry:
  - SKIP/JUMP/CLEAR: 3.
  - STORE: 5.
  - LOAD/ALU ops: 6.
- HALT: `halted` is asserted 3 cycles after FETCH.
- SKIP, JUMP and PC+1 in the same DECODE cycle: the JUMP target wins; SKIP yields PC+2.
- `start` outside IDLE/HALT is ignored.
- `rst` mid-instruction: outputs go to reset values immediately (asynchronous); any partial store is abandoned.
- Store write commits on the rising edge that leaves STORE.

## Configuration
- `ACC_CPU_ILLEGAL_TRAP_EN` defined:
  - Opcodes 0 and B–F enter HALT from DECODE.
  - `illegal` is set; it is cleared only by `rst`.
- Not defined:
  - Those opcodes behave as 3-cycle NOPs (PC+1).
  - `illegal` is tied 0.

## Structure
- Package `acc_cpu_pkg`:
  - opcode enum.
  - state enum.
  - ALU_Sel localparams (OR 00, ADD 01, SUB 10, AND 11).
  - skip-condition codes.
  - RESET_PC default.
- Instantiate the existing `alu` as the single sub-module. Drive it combinationally from AC, MBR and an opcode-derived ALU_Sel.

## Test plan
- Reset, then `start`, with M[100]=1124, M[124]=0005, M[101]=7000: AC=0005, PC=0102, `halted`=1 after 9 cycles.
- ADD/SUB/AND/OR with AC=00F0 and M=0F0F: AC becomes 0FFF, 00F0−0F0F=F1E1, 0000, 0FFF respectively; each takes 6 cycles.
- STORE, with AC=1234 to address 130, then LOAD 130: `mem_we` pulses one cycle with mem_addr=130 and wdata=1234; AC reads back 1234.
- SKIP cases, each from a PC of 0200:
  - AC=0, IR=8400: next PC=0202.
  - AC=8000, IR=8000: next PC=0202.
  - AC=0001, IR=8400: next PC=0201.
- JUMP 9150 then HALT at 150: PC=0151, `halted`=1. A following `start` restarts fetch at 0151.
- `rst` asserted during STORE: `mem_we` drops the same cycle and memory is unchanged. Opcode F000 traps with `illegal`=1 when the macro is defined, and is a NOP with PC+1 when it is not.
